// File: rtl/jk_latch.sv
// Clocked gated JK latch: J/K commands are applied on rising clk while e is high.
// q_bar is always the complement of the registered q.
module jk_latch #(
  parameter logic RESET_Q     = 1'b0,
  parameter int   TOGGLE_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_t;

  cmd_t cmd;
  logic armed;
  logic toggle_ok;
  logic q_next;
  logic armed_next;

  // In one-shot mode a toggle is taken only while armed; otherwise every 11 toggles.
  assign toggle_ok = (TOGGLE_MODE == 0) || armed;

  always_comb begin
    cmd        = e ? cmd_t'({j, k}) : CMD_HOLD;
    q_next     = q;
    armed_next = 1'b1;
    case (cmd)
      CMD_RESET:  q_next = 1'b0;
      CMD_SET:    q_next = 1'b1;
      CMD_TOGGLE: begin
        armed_next = 1'b0;
        if (toggle_ok) q_next = ~q;
      end
      default:    q_next = q;
    endcase
  end

  // NOTE: non-blocking assignments here so q and armed both update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= RESET_Q;
      armed <= 1'b1;
    end else begin
      q     <= q_next;
      armed <= armed_next;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_latch.sv
// Directed bench for jk_latch: runs a toggle-every-edge and a one-shot instance side by side,
// with expected q values queued at drive time and compared after each clock.
module tb_jk_latch;

  typedef struct {
    string tag;
    logic  q0;
    logic  q1;
  } exp_t;

  logic clk;
  logic rst_n;
  logic e, j, k;
  logic q0, q_bar0, q1, q_bar1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  jk_latch #(.RESET_Q(1'b0), .TOGGLE_MODE(0)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .e(e), .j(j), .k(k), .q(q0), .q_bar(q_bar0)
  );

  jk_latch #(.RESET_Q(1'b0), .TOGGLE_MODE(1)) u_mode1 (
    .clk(clk), .rst_n(rst_n), .e(e), .j(j), .k(k), .q(q1), .q_bar(q_bar1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_one(input string tag, input string sig, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s %s observed=%b expected=%b", tag, sig, obs, exp);
  endtask

  task automatic compare();
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      x = sb.pop_front();
      check_one(x.tag, "q0",     q0,     x.q0);
      check_one(x.tag, "q_bar0", q_bar0, ~x.q0);
      check_one(x.tag, "q1",     q1,     x.q1);
      check_one(x.tag, "q_bar1", q_bar1, ~x.q1);
    end
  endtask

  // Drive {e,j,k} away from the edge, queue the expectation, compare just after the edge.
  task automatic step(input string tag, input logic ie, input logic ij, input logic ik,
                      input logic exp0, input logic exp1);
    exp_t x;
    @(negedge clk);
    e = ie; j = ij; k = ik;
    x.tag = tag; x.q0 = exp0; x.q1 = exp1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string tag, input logic exp0, input logic exp1);
    exp_t x;
    x.tag = tag; x.q0 = exp0; x.q1 = exp1;
    sb.push_back(x);
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    e = 1'b1; j = 1'b1; k = 1'b0;

    // Reset held with a set command presented and clk running.
    #2;
    check_now("reset_async", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_now("reset_hold", 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_now("reset_release", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("first_set", 1'b1, 1'b1);

    // Enable-low hold from q=1, then from q=0.
    step("hold_hi_000", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("hold_hi_001", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("hold_hi_010", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("hold_hi_011", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("clear",       1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_lo_000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hold_lo_001", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_lo_010", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("hold_lo_011", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Enabled command table.
    step("cmd_100", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("cmd_101", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("cmd_110", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("cmd_111", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Rearm with a reset command, then hold 111 for four edges.
    step("rearm_101", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("tog_1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("tog_2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step("tog_3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("tog_4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Dropping e re-arms the one-shot instance.
    step("e_low_rearm", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("tog_after_e", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("tog_disarmed", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Leaving 11 with e high also re-arms.
    step("jk_leave_11", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("tog_after_jk", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("tog_mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Async reset between edges while mode-0 instance is toggling with q0=1.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_mid_toggle", 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_now("reset_no_toggle", 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_now("post_reset_toggle", 1'b1, 1'b1);
    step("post_reset_tog2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
